// File: rtl/cnc_pulse_gen_multi.sv
// Multi-axis DDA step/direction generator: a command FIFO is popped once per time slice and
// one DDA accumulator per axis emits step pulses. Define CNC_POS_CNT_EN for position counters.
module cnc_pulse_gen_multi #(
  parameter int unsigned AXES      = 2,
  parameter int unsigned NW        = 8,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned SLICE_CYC = 1000,
  parameter int unsigned TICK_HALF = 50,
  parameter int unsigned ACC_INIT  = 0,
  parameter int unsigned POS_W     = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr,
  input  logic [AXES*NW-1:0]           din,
  input  logic [NW-1:0]                n_div,
  input  logic [AXES-1:0]              ls,
  output logic [AXES-1:0]              step,
  output logic [AXES-1:0]              dir,
  output logic                         flag_t,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic [AXES*POS_W-1:0]        pos
);

  localparam int unsigned MW = NW - 1;
  localparam int unsigned LW = $clog2(DEPTH + 1);
  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned SW = (SLICE_CYC > 1) ? $clog2(SLICE_CYC) : 1;
  localparam int unsigned TP = 2 * TICK_HALF;
  localparam int unsigned TW = (TP > 1) ? $clog2(TP) : 1;

  logic [AXES*NW-1:0] mem_q [DEPTH];
  logic [AXES*NW-1:0] mem_d [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]      count_q, count_d;
  logic               wr_q;
  logic [SW-1:0]      slice_q, slice_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic               flag_q, flag_d;
  logic [MW-1:0]      mag_q [AXES];
  logic [MW-1:0]      mag_d [AXES];
  logic [NW-1:0]      acc_q [AXES];
  logic [NW-1:0]      acc_d [AXES];
  logic [AXES-1:0]    pend_q, pend_d;
  logic [AXES-1:0]    dir_q, dir_d;
  logic [NW:0]        sum [AXES];
  logic [NW:0]        diff [AXES];
  logic [AXES*NW-1:0] head;

  logic wr_rise, any_ls, boundary, tick_wrap, tick_hi, push, pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  always_comb begin
    wr_rise   = wr & ~wr_q;
    any_ls    = |ls;
    full      = (count_q == LW'(DEPTH));
    empty     = (count_q == '0);
    boundary  = (slice_q == SW'(SLICE_CYC - 1));
    tick_wrap = (tick_q == TW'(TP - 1));
    tick_hi   = (tick_q >= TW'(TICK_HALF));
    // full is taken before any same-cycle pop, so a write to a full FIFO is always lost
    push      = wr_rise & (din != '0) & ~any_ls & ~full;
    pop       = boundary & ~any_ls & ~empty;
    level     = count_q;
    flag_t    = flag_q;
    dir       = dir_q;
    head      = mem_q[rd_ptr_q];
  end

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    if (push && !pop)      count_d = count_q + LW'(1);
    else if (pop && !push) count_d = count_q - LW'(1);
    if (any_ls) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_comb begin
    slice_d = boundary ? '0 : slice_q + SW'(1);
    tick_d  = tick_wrap ? '0 : tick_q + TW'(1);
    flag_d  = flag_q ^ boundary;
    dir_d   = dir_q;
    pend_d  = pend_q;
    for (int k = 0; k < AXES; k++) begin
      mag_d[k] = mag_q[k];
      acc_d[k] = acc_q[k];
      sum[k]   = {1'b0, acc_q[k]} + {2'b00, mag_q[k]};
      diff[k]  = sum[k] - {1'b0, n_div};
      if (boundary) begin
        if (pop) begin
          mag_d[k] = head[k*NW +: MW];
          dir_d[k] = head[k*NW + NW - 1];
        end else begin
          mag_d[k] = '0;
        end
      end
      if (tick_wrap) begin
        if (sum[k] > {1'b0, n_div}) begin
          acc_d[k]  = diff[k][NW-1:0];
          pend_d[k] = 1'b1;
        end else begin
          acc_d[k]  = sum[k][NW-1:0];
          pend_d[k] = 1'b0;
        end
      end
    end
  end

  // Limit switches gate their own axis combinationally, without waiting for a clock
  always_comb begin
    step = pend_q & {AXES{tick_hi}} & ~ls;
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      wr_q     <= 1'b0;
      slice_q  <= '0;
      tick_q   <= '0;
      flag_q   <= 1'b0;
      pend_q   <= '0;
      dir_q    <= '0;
      for (int k = 0; k < AXES; k++) begin
        mag_q[k] <= '0;
        acc_q[k] <= NW'(ACC_INIT);
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      wr_q     <= wr;
      slice_q  <= slice_d;
      tick_q   <= tick_d;
      flag_q   <= flag_d;
      pend_q   <= pend_d;
      dir_q    <= dir_d;
      for (int k = 0; k < AXES; k++) begin
        mag_q[k] <= mag_d[k];
        acc_q[k] <= acc_d[k];
      end
    end
  end

`ifdef CNC_POS_CNT_EN
  logic [AXES-1:0]  step_prev_q, step_prev_d;
  logic [POS_W-1:0] pos_q [AXES];
  logic [POS_W-1:0] pos_d [AXES];

  always_comb begin
    step_prev_d = step;
    pos         = '0;
    for (int k = 0; k < AXES; k++) begin
      pos_d[k] = pos_q[k];
      if (step[k] && !step_prev_q[k]) begin
        pos_d[k] = dir_q[k] ? pos_q[k] - POS_W'(1) : pos_q[k] + POS_W'(1);
      end
      pos[k*POS_W +: POS_W] = pos_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_prev_q <= '0;
      for (int k = 0; k < AXES; k++) pos_q[k] <= '0;
    end else begin
      step_prev_q <= step_prev_d;
      for (int k = 0; k < AXES; k++) pos_q[k] <= pos_d[k];
    end
  end
`else
  assign pos = '0;
`endif

endmodule

// File: tb/tb_cnc_pulse_gen_multi.sv
// Directed bench for cnc_pulse_gen_multi with a 100-cycle slice, 10-cycle tick and n_div=10.
module tb_cnc_pulse_gen_multi;

  logic        clk = 1'b0;
  logic        rst, wr;
  logic [15:0] din;
  logic [7:0]  n_div;
  logic [1:0]  ls;
  logic [1:0]  step, dir;
  logic        flag_t, full, empty;
  logic [2:0]  level;
  logic [31:0] pos;
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;

  cnc_pulse_gen_multi #(
    .AXES(2), .NW(8), .DEPTH(4), .SLICE_CYC(100), .TICK_HALF(5), .ACC_INIT(0), .POS_W(16)
  ) dut (
    .clk(clk), .rst(rst), .wr(wr), .din(din), .n_div(n_div), .ls(ls), .step(step),
    .dir(dir), .flag_t(flag_t), .full(full), .empty(empty), .level(level), .pos(pos)
  );

  always #5 clk = ~clk;

  // cyc == k at the falling edge after the k-th rising edge since reset release
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic reset_dut();
    @(negedge clk);
    rst = 1'b1; wr = 1'b0; din = '0; ls = '0; n_div = 8'd10;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic goto(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic test_reset();
    reset_dut();
    total++;
    if ({step, dir, flag_t, full, empty, level} !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      bad++;
      $display("FAIL reset_outputs got=%b want=%b", {step, dir, flag_t, full, empty, level},
               {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0});
    end
    total++;
    if (pos !== 32'h0) begin bad++; $display("FAIL reset_pos got=%h want=0", pos); end
  endtask

  task automatic test_zero_din();
    reset_dut();
    wr = 1'b1; din = 16'h0000;
    goto(1);
    total++;
    if ({level, empty} !== {3'd0, 1'b1}) begin
      bad++; $display("FAIL zero_din_ignored got level=%0d empty=%b want 0 1", level, empty);
    end
    wr = 1'b0;
    goto(2);
    wr = 1'b1; din = 16'h0101;
    goto(4);
    total++;
    if (level !== 3'd1) begin bad++; $display("FAIL held_wr_one_push got=%0d want=1", level); end
    wr = 1'b0;
  endtask

  task automatic test_single_axis();
    int rises, hi0, hi1, run, badw;
    logic p0;
    reset_dut();
    wr = 1'b1; din = 16'h0005;
    goto(1);
    wr = 1'b0;
    total++;
    if (level !== 3'd1) begin bad++; $display("FAIL push_level got=%0d want=1", level); end
    goto(99);
    total++;
    if ({flag_t, level} !== {1'b0, 3'd1}) begin
      bad++; $display("FAIL pre_boundary got flag=%b level=%0d want 0 1", flag_t, level);
    end
    goto(100);
    total++;
    if ({flag_t, level, empty} !== {1'b1, 3'd0, 1'b1}) begin
      bad++; $display("FAIL boundary_pop got flag=%b level=%0d empty=%b want 1 0 1",
                      flag_t, level, empty);
    end
    rises = 0; hi0 = 0; hi1 = 0; run = 0; badw = 0; p0 = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (step[0]) begin hi0++; run++; end
      if (step[0] && !p0) rises++;
      if (!step[0] && p0) begin
        if (run != 5) badw++;
        run = 0;
      end
      if (step[1]) hi1++;
      p0 = step[0];
    end
    total++;
    if (rises !== 4) begin bad++; $display("FAIL ax0_pulse_count got=%0d want=4", rises); end
    total++;
    if (hi0 !== 20) begin bad++; $display("FAIL ax0_high_cycles got=%0d want=20", hi0); end
    total++;
    if (badw !== 0) begin bad++; $display("FAIL ax0_pulse_width got=%0d bad want=0", badw); end
    total++;
    if (hi1 !== 0) begin bad++; $display("FAIL ax1_idle got=%0d want=0", hi1); end
  endtask

  task automatic test_fifo_full();
    logic [15:0] cmds [5];
    logic [1:0]  exp_dir [4];
    cmds = '{16'h0001, 16'h0081, 16'h8101, 16'h8181, 16'h0101};
    exp_dir = '{2'b00, 2'b01, 2'b10, 2'b11};
    reset_dut();
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; din = cmds[i];
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
    end
    total++;
    if ({level, full, empty} !== {3'd4, 1'b1, 1'b0}) begin
      bad++; $display("FAIL fifo_full got level=%0d full=%b empty=%b want 4 1 0",
                      level, full, empty);
    end
    for (int b = 1; b <= 4; b++) begin
      goto(100 * b);
      total++;
      if ({dir, level} !== {exp_dir[b-1], 3'(4 - b)}) begin
        bad++; $display("FAIL pop_order_%0d got dir=%b level=%0d want dir=%b level=%0d",
                        b, dir, level, exp_dir[b-1], 4 - b);
      end
    end
    total++;
    if (empty !== 1'b1) begin bad++; $display("FAIL drained_empty got=%b want=1", empty); end
    goto(500);
    total++;
    if ({dir, level} !== {2'b11, 3'd0}) begin
      bad++; $display("FAIL fifth_dropped got dir=%b level=%0d want 11 0", dir, level);
    end
  endtask

  task automatic test_dir_neg();
    int rises, hi0;
    logic p1;
    reset_dut();
    wr = 1'b1; din = 16'h8500;
    goto(1);
    wr = 1'b0;
    goto(100);
    total++;
    if (dir !== 2'b10) begin bad++; $display("FAIL neg_dir got=%b want=10", dir); end
    rises = 0; hi0 = 0; p1 = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (step[1] && !p1) rises++;
      if (step[0]) hi0++;
      p1 = step[1];
    end
    total++;
    if (rises !== 4) begin bad++; $display("FAIL ax1_pulse_count got=%0d want=4", rises); end
    total++;
    if (hi0 !== 0) begin bad++; $display("FAIL ax0_idle_neg got=%0d want=0", hi0); end
    total++;
`ifdef CNC_POS_CNT_EN
    if (pos !== 32'hFFFC_0000) begin bad++; $display("FAIL pos_neg got=%h want=fffc0000", pos); end
`else
    if (pos !== 32'h0) begin bad++; $display("FAIL pos_tied got=%h want=0", pos); end
`endif
  endtask

  task automatic test_limit();
    int rises, hi;
    logic p1;
    reset_dut();
    wr = 1'b1; din = 16'h0505;
    goto(1);
    wr = 1'b0;
    goto(100);
    for (int i = 0; i < 3; i++) begin
      wr = 1'b1; din = 16'h0303;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
    end
    total++;
    if (level !== 3'd3) begin bad++; $display("FAIL ls_queued got=%0d want=3", level); end
    goto(136);
    total++;
    if (step !== 2'b11) begin bad++; $display("FAIL ls_pre_step got=%b want=11", step); end
    ls = 2'b01;
    #1;
    total++;
    if (step !== 2'b10) begin bad++; $display("FAIL ls_step_drop got=%b want=10", step); end
    goto(137);
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL ls_flush got=%0d want=0", level); end
    wr = 1'b1; din = 16'h0202;
    goto(138);
    wr = 1'b0;
    goto(140);
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL ls_write_ignored got=%0d want=0", level); end
    ls = 2'b00;
    goto(141);
    total++;
    if (level !== 3'd0) begin bad++; $display("FAIL ls_release_level got=%0d want=0", level); end
    rises = 0; p1 = step[1];
    while (cyc < 200) begin
      @(negedge clk);
      if (step[1] && !p1) rises++;
      p1 = step[1];
    end
    total++;
    if (rises !== 3) begin bad++; $display("FAIL ls_ax1_continues got=%0d want=3", rises); end
    hi = 0;
    while (cyc < 300) begin
      @(negedge clk);
      if (step != 2'b00) hi++;
    end
    total++;
    if (hi !== 0) begin bad++; $display("FAIL ls_after_boundary got=%0d want=0", hi); end
  endtask

  task automatic test_same_cycle();
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; din = 16'h0101;
      @(negedge clk);
      wr = 1'b0;
      @(negedge clk);
    end
    goto(99);
    wr = 1'b1; din = 16'h0101;
    goto(100);
    wr = 1'b0;
    total++;
    if ({level, full} !== {3'd3, 1'b0}) begin
      bad++; $display("FAIL full_push_pop got level=%0d full=%b want 3 0", level, full);
    end
    reset_dut();
    goto(99);
    wr = 1'b1; din = 16'h8181;
    goto(100);
    wr = 1'b0;
    total++;
    if ({level, dir} !== {3'd1, 2'b00}) begin
      bad++; $display("FAIL empty_push_pop got level=%0d dir=%b want 1 00", level, dir);
    end
    goto(200);
    total++;
    if ({level, dir} !== {3'd0, 2'b11}) begin
      bad++; $display("FAIL late_cmd_pop got level=%0d dir=%b want 0 11", level, dir);
    end
  endtask

  task automatic test_reset_mid();
    int hi;
    reset_dut();
    wr = 1'b1; din = 16'h8585;
    goto(1);
    wr = 1'b0;
    goto(136);
    total++;
    if ({step, dir, flag_t} !== {2'b11, 2'b11, 1'b1}) begin
      bad++; $display("FAIL mid_pre got=%b want=11111", {step, dir, flag_t});
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({step, dir, flag_t, full, empty, level} !== {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0}) begin
      bad++; $display("FAIL mid_reset got=%b want=%b", {step, dir, flag_t, full, empty, level},
                      {2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 3'd0});
    end
    total++;
    if (pos !== 32'h0) begin bad++; $display("FAIL mid_reset_pos got=%h want=0", pos); end
    rst = 1'b0;
    hi = 0;
    repeat (150) begin
      @(negedge clk);
      if (step != 2'b00) hi++;
    end
    total++;
    if (hi !== 0) begin bad++; $display("FAIL post_reset_idle got=%0d want=0", hi); end
  endtask

  initial begin
    rst = 1'b1; wr = 1'b0; din = '0; ls = '0; n_div = 8'd10;
    test_reset();
    test_zero_din();
    test_single_axis();
    test_fifo_full();
    test_dir_neg();
    test_limit();
    test_same_cycle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
